// File: rtl/rock_core_pkg.sv
// Shared definitions for the rock core front end: datapath width, reset PC,
// the canonical NOP encoding and the fetch state encoding.
package rock_core_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with +4 sequencing and word-aligned redirect.
// A redirect always wins over a sequential advance.
module fetch_pc_reg
  import rock_core_pkg::*;
#(
  parameter int              XLEN     = rock_core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rock_core_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] pc_nxt;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  always_comb begin
    pc_nxt = pc_p0;
    if (redirect_valid) begin
      pc_nxt = word_align(redirect_target);
    end else if (advance) begin
      pc_nxt = pc_p0 + PC_STEP;
    end
  end

  // PC register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC;
    end else begin
      pc_p0 <= pc_nxt;
    end
  end

  assign pc = pc_p0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch stage: issues word requests to imem,
// captures the returned word and hands it to decode with its PC and link value.
module instruction_fetch_unit
  import rock_core_pkg::*;
#(
  parameter int              XLEN     = rock_core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rock_core_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_t    state_p0;
  fetch_state_t    state_nxt;
  logic            capture;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr_word_p1;
  logic [XLEN-1:0] instr_pc_p1;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .advance         (capture),
    .pc              (pc)
  );

  // A response can only be kept when it lands in WAIT with no redirect pending.
  always_comb begin
    state_nxt = state_p0;
    capture   = 1'b0;
    unique case (state_p0)
      FETCH: begin
        if (imem_req_ready) begin
          state_nxt = redirect_valid ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_nxt = imem_resp_valid ? FETCH : DRAIN;
        end else if (imem_resp_valid) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || instr_ready) begin
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        // Redirects here only move the PC; the stale response must still be absorbed.
        if (imem_resp_valid) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // FSM state stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= FETCH;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Instruction capture stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_word_p1 <= NOP_INSTR;
      instr_pc_p1   <= RESET_PC;
    end else if (capture) begin
      instr_word_p1 <= imem_resp_data;
      instr_pc_p1   <= pc;
    end
  end

  assign imem_req_valid = (state_p0 == FETCH);
  assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
  assign instr_valid    = (state_p0 == HOLD);
  assign instruction    = instr_word_p1;
  assign instr_pc       = instr_pc_p1;
  assign instr_pc_plus4 = instr_pc_p1 + PC_STEP;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: table-driven sequential fetches
// plus directed redirect, wrap-around and reset sequences, with a delivery scoreboard.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          stall;
  } vec_t;
  vec_t vecs[3];

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc),
    .instr_pc_plus4  (instr_pc_plus4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Accept one request at exp_addr, return word next cycle, hold it for stall cycles, retire it.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word, input int stall);
    exp_t e;
    int   n;
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_req_addr, exp_addr);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    sb.push_back('{word: word, pc: exp_addr, pc4: exp_addr + 32'd4});
    imem_resp_valid = 1'b1;
    imem_resp_data  = word;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    n = 0;
    while (!instr_valid && n < 8) begin
      step();
      n++;
    end
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("instruction", instruction, e.word);
      chk("instr_pc", instr_pc, e.pc);
      chk("instr_pc_plus4", instr_pc_plus4, e.pc4);
    end
    for (int i = 0; i < stall; i++) begin
      step();
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_instruction", instruction, word);
      chk("hold_pc", instr_pc, exp_addr);
      chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("retired_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{addr: 32'h0000_0000, word: 32'h0050_0093, stall: 0};
    vecs[1] = '{addr: 32'h0000_0004, word: 32'h00a0_0113, stall: 0};
    vecs[2] = '{addr: 32'h0000_0008, word: 32'h1111_2222, stall: 5};

    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    instr_ready     = 1'b0;
    step();
    step();
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instruction", instruction, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc_plus4", instr_pc_plus4, 32'h4);
    rst_n = 1'b1;
    step();
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Memory not ready: request stays up, address stable, nothing advances.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_req_addr", imem_req_addr, 32'h0);
      chk("stall_no_instr", {31'd0, instr_valid}, 32'd0);
    end

    for (int i = 0; i < 3; i++) begin
      fetch_one(vecs[i].addr, vecs[i].word, vecs[i].stall);
    end

    // Redirect while WAIT; stale response arrives later and is dropped.
    chk("pre_wait_addr", imem_req_addr, 32'hC);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    chk("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    chk("drain_no_req2", {31'd0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    chk("drop_no_instr", {31'd0, instr_valid}, 32'd0);
    chk("drop_instr_kept", instruction, 32'h1111_2222);
    fetch_one(32'h0000_0100, 32'h0000_0517, 0);

    // Redirect in HOLD with instr_ready high.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0040_006F;
    step();
    imem_resp_valid = 1'b0;
    chk("hold_redir_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_redir_pc", instr_pc, 32'h104);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    instr_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    chk("hold_redir_cleared", {31'd0, instr_valid}, 32'd0);
    chk("hold_redir_addr", imem_req_addr, 32'h40);

    // Redirect coincident with a response in WAIT.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0080;
    step();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    chk("wait_redir_no_instr", {31'd0, instr_valid}, 32'd0);
    chk("wait_redir_req", {31'd0, imem_req_valid}, 32'd1);
    chk("wait_redir_addr", imem_req_addr, 32'h80);

    // Redirect in FETCH without handshake: address moves next cycle.
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0202;
    step();
    redirect_valid = 1'b0;
    chk("fetch_redir_addr", imem_req_addr, 32'h200);

    // Redirect with handshake in FETCH: stale request drained, then wrap-around fetch.
    imem_req_ready  = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("fetch_hs_drain", {31'd0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h5555_5555;
    step();
    imem_resp_valid = 1'b0;
    chk("fetch_hs_no_instr", {31'd0, instr_valid}, 32'd0);
    fetch_one(32'hFFFF_FFFC, 32'h0000_0073, 0);
    chk("wrap_addr", imem_req_addr, 32'h0);

    // Reset mid-WAIT; late response must be ignored.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_instruction", instruction, 32'h0000_0013);
    chk("midrst_instr_pc", instr_pc, 32'h0);
    chk("midrst_pc_plus4", instr_pc_plus4, 32'h4);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hCAFE_F00D;
    step();
    imem_resp_valid = 1'b0;
    chk("late_resp_no_instr", {31'd0, instr_valid}, 32'd0);
    chk("late_resp_instruction", instruction, 32'h0000_0013);
    chk("late_resp_req", {31'd0, imem_req_valid}, 32'd1);
    chk("late_resp_addr", imem_req_addr, 32'h0);
    fetch_one(32'h0, 32'h0050_0093, 0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage that sits directly upstream of the control decoder. It owns the program counter and issues one word-aligned request at a time to instruction memory over a valid/ready handshake. It captures the returned word and presents it, with its PC, to the decode/execute stage through a valid/ready handshake. Redirects from jal, jalr and branches have priority, and any fetch already in flight when a redirect arrives is discarded.

## Interface
- `XLEN`, 32, datapath/address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `imem_req_valid` out 1: fetch request valid
- `imem_req_ready` in 1: memory accepts request
- `imem_req_addr` out XLEN: fetch address, always `pc` with [1:0]=00
- `imem_resp_valid` in 1: response word valid (one per accepted request, ≥1 cycle after accept)
- `imem_resp_data` in 32: instruction word
- `redirect_valid` in 1: PC redirect from execute
- `redirect_target` in XLEN: new PC; bits [1:0] forced to 00
- `instr_valid` out 1: `instruction` valid for decode
- `instr_ready` in 1: decode/execute consumes instruction
- `instruction` out 32: registered instruction word
- `instr_pc` out XLEN: PC of `instruction`
- `instr_pc_plus4` out XLEN: `instr_pc`+4, the jal/jalr link value

## Operation
- States: FETCH, WAIT, HOLD, DRAIN. One outstanding request maximum.
- FETCH:
  - `imem_req_valid`=1, `imem_req_addr`=pc.
  - On handshake → WAIT.
- WAIT:
  - On `imem_resp_valid` → capture data into `instruction`, pc into `instr_pc`.
  - Then pc ← pc+4, `instr_valid` ← 1, → HOLD.
- HOLD:
  - `instr_valid`=1; outputs stable.
  - On `instr_ready` → `instr_valid` ← 0, → FETCH.
- DRAIN:
  - `imem_req_valid`=0.
  - On `imem_resp_valid` the word is discarded → FETCH.
- Redirect has priority over everything. In all cases pc ← {redirect_target[XLEN-1:2], 2'b00}.
  - FETCH, no handshake: stay FETCH. Address changes next cycle; memory must tolerate address change while valid && !ready.
  - FETCH with handshake same cycle: → DRAIN (stale request).
  - WAIT, no response: → DRAIN.
  - WAIT with response same cycle: response discarded, → FETCH.
  - HOLD: `instr_valid` ← 0 regardless of `instr_ready` (held instruction counts as retired), → FETCH.
  - DRAIN: stay DRAIN.
- `imem_resp_valid` in FETCH or HOLD is ignored.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Reset values:
  - state=FETCH, pc=RESET_PC
  - `instr_valid`=0, `instruction`=32'h0000_0013 (addi x0,x0,0)
  - `instr_pc`=RESET_PC, `instr_pc_plus4`=RESET_PC+4
  - `imem_req_valid`=1 from the first cycle after reset release
- Reset asserted mid-operation: immediately returns to reset values. A response to a pre-reset request is ignored because state is FETCH.

## Timing
- `imem_req_valid`, `imem_req_addr` and `instr_valid` are registered-state decodes with no combinational path from inputs. Exception: none; redirect affects the address only from the next cycle.
- Zero-wait memory (ready=1, response one cycle after accept):
  - Cycle 0: request accepted.
  - Cycle 1: response captured.
  - Cycle 2: `instr_valid`=1.
  - With `instr_ready` held high, one instruction every 3 cycles.
- Redirect → first request at target: next cycle from FETCH or HOLD; the cycle after the discarded response from WAIT or DRAIN.
- `instruction` and `instr_pc` change only on the WAIT capture edge.

## Structure
- Shared package `rock_core_pkg` holds:
  - `XLEN` and `RESET_PC` default
  - `NOP_INSTR` = 32'h0000_0013
  - `fetch_state_t` enum {FETCH, WAIT, HOLD, DRAIN}
- One sub-module: `fetch_pc_reg`. It contains the PC register, +4 incrementer, redirect mux and low-bit masking, with async active-low reset to `RESET_PC`.
- FSM and output registers live in `instruction_fetch_unit`.

## Test plan
- Reset release, ready=1, 1-cycle responses 0x00500093, 0x00a00113, `instr_ready`=1 → addresses 0x0, 0x4. Both words appear with `instr_pc` 0x0/0x4 and `instr_pc_plus4` 0x4/0x8. `instr_valid` pulses every 3 cycles.
- `imem_req_ready` low 4 cycles → `imem_req_valid` and address 0x0 held stable. No state advance.
- Word held in HOLD, `instr_ready`=0 for 5 cycles → `instruction` and `instr_pc` unchanged, `instr_valid` stays 1, no new request.
- Redirect to 0x103 while WAIT, response arrives 2 cycles later with 0xDEADBEEF → word discarded, `instr_valid` never rises for it. Next request address is 0x100.
- Redirect in HOLD with `instr_ready`=1, target 0x40 → `instr_valid` 0 next cycle, next request 0x40. Redirect together with a response in WAIT → response dropped, FETCH at target.
- PC 0xFFFFFFFC fetched → next request 0x00000000. Assert `rst_n` mid-WAIT → outputs return to NOP/RESET_PC, and a late response is ignored.
